// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_responder: multi-cycle data-memory responder for the MEM stage   |
// | (valid/ready request, one-cycle response pulse, pipeline stall).      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              stall
);

  localparam logic [3:0] c_wait = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_write;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_access;
  logic [DATA_W-1:0]   r_mem [0:(2**ADDR_W)-1];

  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_access)  w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && req_valid) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_write <= req_write;
        r_cnt   <= c_wait;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_access) begin
        r_rdata <= r_write ? r_wdata : r_mem[r_addr];
      end
    end
  end

  // Storage is deliberately left out of reset; an async reset clears
  // r_state first, so a pending store can never reach the array.
  always_ff @(posedge clk) begin
    if (w_access && r_write) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign stall      = ((r_state == S_IDLE) && req_valid) || (r_state == S_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_responder: randomized self-checking bench for dmem_responder  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_dmem_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       v2 = 1'b0, v0 = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       rdy2, rv2, stall2, rdy0, rv0, stall0;
  logic [7:0] rd2, rd0;

  int checks = 0;
  int failures = 0;
  int pulses2 = 0, pulses0 = 0;

  logic [7:0] m2 [256];
  bit         k2 [256];
  logic [7:0] m0 [256];
  bit         k0 [256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy2),
    .resp_valid(rv2), .resp_rdata(rd2), .stall(stall2)
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy0),
    .resp_valid(rv0), .resp_rdata(rd0), .stall(stall0)
  );

  always @(negedge clk) begin
    if (rv2) pulses2++;
    if (rv0) pulses0++;
  end

  // Presents one request, optionally alters the fields after accept, and
  // returns the observed timing. The request is still held on return.
  task automatic drive(input bit s0, input bit wr, input logic [7:0] a,
                       input logic [7:0] d, input bit mut,
                       input logic [7:0] ma, input logic [7:0] md,
                       output logic [7:0] rd, output int lat, output int stl,
                       output bit pre_ok, output bit resp_stall,
                       output bit post_rdy, output bit to);
    int n;
    @(negedge clk);
    req_write = wr; req_addr = a; req_wdata = d;
    if (s0) v0 = 1'b1; else v2 = 1'b1;
    #1;
    pre_ok = s0 ? (rdy0 && stall0) : (rdy2 && stall2);
    @(posedge clk);
    n = 0; stl = 0; to = 1'b1; rd = 8'h00; lat = -1; resp_stall = 1'b1;
    while (n < 40) begin
      @(negedge clk);
      if (mut && n == 0) begin req_addr = ma; req_wdata = md; end
      if (s0 ? rv0 : rv2) begin
        lat = n; rd = s0 ? rd0 : rd2; to = 1'b0;
        resp_stall = s0 ? stall0 : stall2;
        break;
      end
      if (s0 ? stall0 : stall2) stl++;
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    post_rdy = s0 ? rdy0 : rdy2;
  endtask

  task automatic idle();
    v0 = 1'b0; v2 = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2;
    v2 = 1'b1; v0 = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (rv2 !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", rv2); end
    checks++; if (rd2 !== 8'h00) begin failures++; $display("FAIL reset_rdata got=%h exp=00", rd2); end
    checks++; if (rdy2 !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", rdy2); end
    checks++; if (stall2 !== 1'b1) begin failures++; $display("FAIL reset_stall_valid got=%b exp=1", stall2); end
    v2 = 1'b0; v0 = 1'b0;
    #1;
    checks++; if (stall2 !== 1'b0) begin failures++; $display("FAIL reset_stall_novalid got=%b exp=0", stall2); end
    checks++; if (stall0 !== 1'b0 || rd0 !== 8'h00) begin failures++; $display("FAIL reset_dut0 got stall=%b rdata=%h exp 0/00", stall0, rd0); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    logic [7:0] rd; int lat, stl; bit pre, rs, pr, to;
    drive(1'b0, 1'b1, 8'h10, 8'h3C, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle(); m2[8'h10] = 8'h3C; k2[8'h10] = 1'b1;
    checks++; if (to || lat != 3) begin failures++; $display("FAIL store_latency got=%0d exp=3 timeout=%0b", lat, to); end
    checks++; if (stl != 3) begin failures++; $display("FAIL store_stall_cycles got=%0d exp=3", stl); end
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL store_rdata got=%h exp=3c", rd); end
    checks++; if (!pre || rs) begin failures++; $display("FAIL store_stall_edges pre=%0b resp=%0b exp 1/0", pre, rs); end
    drive(1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (to || lat != 3) begin failures++; $display("FAIL load_latency got=%0d exp=3 timeout=%0b", lat, to); end
    checks++; if (stl != 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stl); end
    checks++; if (rd !== 8'h3C) begin failures++; $display("FAIL load_rdata got=%h exp=3c", rd); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; int lat, stl; bit pre, rs, pr, to; int p0;
    p0 = pulses2;
    drive(1'b0, 1'b1, 8'hFF, 8'hA5, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    m2[8'hFF] = 8'hA5; k2[8'hFF] = 1'b1;
    checks++; if (pr !== 1'b1) begin failures++; $display("FAIL b2b_not_reaccepted ready=%b exp=1", pr); end
    drive(1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (to || lat != 3 || rd !== 8'hA5) begin failures++; $display("FAIL b2b_load got lat=%0d rdata=%h exp 3/a5", lat, rd); end
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (pulses2 - p0 != 2) begin failures++; $display("FAIL b2b_pulses got=%0d exp=2", pulses2 - p0); end
  endtask

  task automatic test_wait0();
    logic [7:0] rd; int lat, stl; bit pre, rs, pr, to;
    drive(1'b1, 1'b1, 8'h00, 8'h7E, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle(); m0[8'h00] = 8'h7E; k0[8'h00] = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (to || lat != 1) begin failures++; $display("FAIL w0_latency got=%0d exp=1", lat); end
    checks++; if (stl != 1 || !pre || rs) begin failures++; $display("FAIL w0_stall got=%0d pre=%0b resp=%0b exp 1/1/0", stl, pre, rs); end
    checks++; if (rd !== 8'h7E) begin failures++; $display("FAIL w0_rdata got=%h exp=7e", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] rd; int lat, stl; bit pre, rs, pr, to; int p0;
    drive(1'b0, 1'b1, 8'h20, 8'h55, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle(); m2[8'h20] = 8'h55; k2[8'h20] = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h20; req_wdata = 8'h99; v2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (rdy2 !== 1'b1 || rv2 !== 1'b0 || rd2 !== 8'h00) begin failures++; $display("FAIL midwait_reset got ready=%b rv=%b rdata=%h exp 1/0/00", rdy2, rv2, rd2); end
    v2 = 1'b0;
    p0 = pulses2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    checks++; if (pulses2 != p0) begin failures++; $display("FAIL midwait_spurious got=%0d exp=0", pulses2 - p0); end
    drive(1'b0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (to || rd !== 8'h55) begin failures++; $display("FAIL midwait_mem got=%h exp=55", rd); end
  endtask

  task automatic test_field_change();
    logic [7:0] rd; int lat, stl; bit pre, rs, pr, to;
    drive(1'b0, 1'b1, 8'h31, 8'hC7, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle(); m2[8'h31] = 8'hC7; k2[8'h31] = 1'b1;
    drive(1'b0, 1'b1, 8'h30, 8'h11, 1'b1, 8'h31, 8'h22, rd, lat, stl, pre, rs, pr, to);
    idle(); m2[8'h30] = 8'h11; k2[8'h30] = 1'b1;
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL chg_store_rdata got=%h exp=11", rd); end
    drive(1'b0, 1'b0, 8'h30, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (rd !== 8'h11) begin failures++; $display("FAIL chg_mem30 got=%h exp=11", rd); end
    drive(1'b0, 1'b0, 8'h31, 8'h00, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
    idle();
    checks++; if (rd !== 8'hC7) begin failures++; $display("FAIL chg_mem31 got=%h exp=c7", rd); end
  endtask

  task automatic test_random();
    logic [7:0] rd, a, d, exp_rd; int lat, stl, elat; bit pre, rs, pr, to, wr, s0, known;
    for (int i = 0; i < 60; i++) begin
      s0 = ($urandom_range(0, 3) == 0);
      wr = $urandom_range(0, 1);
      a  = 8'(8'h40 + $urandom_range(0, 15));
      d  = 8'($urandom);
      drive(s0, wr, a, d, 1'b0, 8'h00, 8'h00, rd, lat, stl, pre, rs, pr, to);
      idle();
      elat = s0 ? 1 : 3;
      known = 1'b1;
      if (wr) begin
        exp_rd = d;
        if (s0) begin m0[a] = d; k0[a] = 1'b1; end else begin m2[a] = d; k2[a] = 1'b1; end
      end else begin
        known  = s0 ? k0[a] : k2[a];
        exp_rd = s0 ? m0[a] : m2[a];
      end
      checks++; if (to || lat != elat || stl != elat) begin failures++; $display("FAIL rnd_timing i=%0d got lat=%0d stall=%0d exp=%0d", i, lat, stl, elat); end
      checks++; if (!pre || rs || !pr) begin failures++; $display("FAIL rnd_handshake i=%0d got pre=%0b resp_stall=%0b post_ready=%0b exp 1/0/1", i, pre, rs, pr); end
      if (known) begin
        checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rnd_rdata i=%0d addr=%h got=%h exp=%h", i, a, rd, exp_rd); end
      end
      @(negedge clk);
      checks++; if ((s0 ? rd0 : rd2) !== rd) begin failures++; $display("FAIL rnd_hold i=%0d got=%h exp=%h", i, s0 ? rd0 : rd2, rd); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin k2[i] = 1'b0; k0[i] = 1'b0; m2[i] = 8'h00; m0[i] = 8'h00; end
    test_reset();
    test_store_load();
    test_back_to_back();
    test_wait0();
    test_reset_mid_wait();
    test_field_change();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
